// File: rtl/uart_result_sequencer_pkg.sv
// Shared definitions for the UART result sequencer: state encoding,
// frame defaults and the word-to-byte helper.
package uart_result_sequencer_pkg;

  // Frame sequencing states
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_SYNC_TX = 4'd1,
    S_SYNC_WT = 4'd2,
    S_RD_REQ  = 4'd3,
    S_RD_CAP  = 4'd4,
    S_B_TX    = 4'd5,
    S_B_WT    = 4'd6,
    S_C_TX    = 4'd7,
    S_C_WT    = 4'd8
  } seq_state_t;

  localparam int unsigned DEPTH_DEF     = 64;
  localparam int unsigned ADDR_W_DEF    = 6;
  localparam int unsigned WORD_W_DEF    = 32;
  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

  // Number of UART bytes carried by one memory word
  function automatic int unsigned bytes_per_word(input int unsigned word_w);
    return word_w / 8;
  endfunction

endpackage

// File: rtl/uart_result_sequencer.sv
// Streams the output memory to the 8N1 UART as one framed packet:
// SYNC byte, DEPTH words LSB-byte first, then an 8-bit payload checksum.
// Ports:
//   clk, reset_n             clock / async active-low reset
//   start, abort             frame request / stop after current byte
//   mem_rd_en, mem_addr      output memory read request
//   mem_rdata                read data, valid 1 cycle after mem_rd_en
//   tx_byte, tx_send         UART byte and 1-cycle send pulse
//   tx_done                  UART byte-complete pulse
//   busy, done, aborted      frame status
//   checksum                 running payload sum mod 256
module uart_result_sequencer
  import uart_result_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned WORD_W    = WORD_W_DEF,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [7:0]        tx_byte,
  output logic              tx_send,
  input  logic              tx_done,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [7:0]        checksum
);

  localparam int unsigned BPW  = bytes_per_word(WORD_W);
  localparam int unsigned BI_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);
  localparam logic [BI_W-1:0]   LAST_BYTE = BI_W'(BPW - 1);

  seq_state_t        state;
  logic [ADDR_W-1:0] word_idx;
  logic [BI_W-1:0]   byte_idx;
  logic [WORD_W-1:0] shreg;
  logic              abort_q;

  logic [WORD_W-1:0] shreg_shift;
  logic              abort_hit;

  // Next payload byte sits in the low lane once the register is shifted
  assign shreg_shift = shreg >> 8;
  // A same-cycle abort counts as if it had already been latched
  assign abort_hit   = abort_q | abort;

  // Sequencer: outputs are registered for the state being entered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      word_idx  <= '0;
      byte_idx  <= '0;
      shreg     <= '0;
      abort_q   <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      tx_byte   <= 8'h00;
      tx_send   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      checksum  <= 8'h00;
    end else begin
      tx_send   <= 1'b0;
      mem_rd_en <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;

      if (state != S_IDLE && abort) begin
        abort_q <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          // start together with abort is dropped
          if (start && !abort) begin
            state    <= S_SYNC_TX;
            busy     <= 1'b1;
            checksum <= 8'h00;
            abort_q  <= 1'b0;
            tx_byte  <= SYNC_BYTE;
            tx_send  <= 1'b1;
          end
        end

        S_SYNC_TX: state <= S_SYNC_WT;

        S_SYNC_WT: begin
          if (tx_done) begin
            if (abort_hit) begin
              state   <= S_IDLE;
              busy    <= 1'b0;
              aborted <= 1'b1;
              abort_q <= 1'b0;
            end else begin
              word_idx  <= '0;
              mem_addr  <= '0;
              mem_rd_en <= 1'b1;
              state     <= S_RD_REQ;
            end
          end
        end

        S_RD_REQ: state <= S_RD_CAP;

        S_RD_CAP: begin
          shreg    <= mem_rdata;
          byte_idx <= '0;
          tx_byte  <= mem_rdata[7:0];
          tx_send  <= 1'b1;
          checksum <= checksum + mem_rdata[7:0];
          state    <= S_B_TX;
        end

        S_B_TX: state <= S_B_WT;

        S_B_WT: begin
          if (tx_done) begin
            shreg <= shreg_shift;
            if (abort_hit) begin
              state   <= S_IDLE;
              busy    <= 1'b0;
              aborted <= 1'b1;
              abort_q <= 1'b0;
            end else if (byte_idx != LAST_BYTE) begin
              byte_idx <= byte_idx + 1'b1;
              tx_byte  <= shreg_shift[7:0];
              tx_send  <= 1'b1;
              checksum <= checksum + shreg_shift[7:0];
              state    <= S_B_TX;
            end else if (word_idx != LAST_WORD) begin
              word_idx  <= word_idx + 1'b1;
              mem_addr  <= word_idx + 1'b1;
              mem_rd_en <= 1'b1;
              state     <= S_RD_REQ;
            end else begin
              tx_byte <= checksum;
              tx_send <= 1'b1;
              state   <= S_C_TX;
            end
          end
        end

        S_C_TX: state <= S_C_WT;

        S_C_WT: begin
          if (tx_done) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            abort_q <= 1'b0;
            if (abort_hit) begin
              aborted <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_result_sequencer.sv
// Self-checking bench for uart_result_sequencer with a timed UART model,
// a one-cycle-latency memory model and a frame-level reference model.
module tb_uart_result_sequencer;

  localparam int unsigned DEPTH  = 2;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned WORD_W = 32;
  localparam logic [7:0]  SYNC   = 8'hA5;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic              abort;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_rdata;
  logic [7:0]        tx_byte;
  logic              tx_send;
  logic              tx_done;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [7:0]        checksum;

  logic        uart_done;
  logic        inj_done;
  int          uart_cnt;
  logic [31:0] mem [DEPTH];

  int total = 0;
  int bad   = 0;

  // Monitor state
  logic [7:0] sent [$];
  logic [7:0] exp_q [$];
  logic [7:0] exp_sum;
  logic       inflight;
  logic [7:0] held;
  int done_cnt    = 0;
  int abort_cnt   = 0;
  int stab_viol   = 0;
  int twice_viol  = 0;
  int addr_viol   = 0;

  assign tx_done = uart_done | inj_done;

  uart_result_sequencer #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .WORD_W(WORD_W), .SYNC_BYTE(SYNC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .tx_byte(tx_byte), .tx_send(tx_send), .tx_done(tx_done),
    .busy(busy), .done(done), .aborted(aborted), .checksum(checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART model: tx_done about 10 cycles after each tx_send
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uart_cnt  <= 0;
      uart_done <= 1'b0;
    end else begin
      uart_done <= (uart_cnt == 1);
      if (tx_send) uart_cnt <= 10;
      else if (uart_cnt != 0) uart_cnt <= uart_cnt - 1;
    end
  end

  // Memory model: data valid the cycle after the read strobe
  always @(posedge clk) begin
    if (mem_rd_en && mem_addr < ADDR_W'(DEPTH)) mem_rdata <= mem[int'(mem_addr)];
  end

  // Protocol monitor: records sent bytes and handshake violations
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight <= 1'b0;
      held     <= 8'h00;
    end else begin
      if (mem_rd_en && mem_addr >= ADDR_W'(DEPTH)) addr_viol++;
      if (inflight && tx_send) twice_viol++;
      if (inflight && tx_byte !== held) stab_viol++;
      if (tx_send) begin
        inflight <= 1'b1;
        held     <= tx_byte;
        sent.push_back(tx_byte);
      end else if (tx_done) begin
        inflight <= 1'b0;
      end
      if (done) done_cnt++;
      if (aborted) abort_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame computed directly from memory contents
  task automatic build_exp();
    logic [31:0] w;
    logic [7:0]  b;
    exp_q.delete();
    exp_sum = 8'h00;
    exp_q.push_back(SYNC);
    for (int i = 0; i < int'(DEPTH); i++) begin
      w = mem[i];
      for (int k = 0; k < 4; k++) begin
        b = 8'((w >> (8 * k)) & 32'hFF);
        exp_sum = exp_sum + b;
        exp_q.push_back(b);
      end
    end
    exp_q.push_back(exp_sum);
  endtask

  task automatic compare_frame(input string tag, input int base);
    check({tag, "_len"}, 32'(sent.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < sent.size())
        check($sformatf("%s_b%0d", tag, i), 32'(sent[base + i]), 32'(exp_q[i]));
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int n = 0;
    while (done !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(n < maxc), 32'd1);
  endtask

  task automatic wait_aborted(input string tag, input int maxc);
    int n = 0;
    while (aborted !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_aborted_seen"}, 32'(n < maxc), 32'd1);
  endtask

  task automatic wait_sent(input string tag, input int cnt, input int maxc);
    int n = 0;
    while (sent.size() < cnt && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_sent_reached"}, 32'(n < maxc), 32'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_aborted"}, 32'(aborted), 32'd0);
    check({tag, "_tx_send"}, 32'(tx_send), 32'd0);
    check({tag, "_tx_byte"}, 32'(tx_byte), 32'd0);
    check({tag, "_mem_rd_en"}, 32'(mem_rd_en), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_checksum"}, 32'(checksum), 32'd0);
  endtask

  initial begin
    int base;
    int dbase;
    int abase;
    start    = 1'b0;
    abort    = 1'b0;
    inj_done = 1'b0;
    reset_n  = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'h0403_0201 + 32'(i) * 32'h0404_0404;
    #1 reset_n = 1'b0;
    cycles(3);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    cycles(2);

    // T1: one full frame, first send one cycle after start
    build_exp();
    base  = sent.size();
    dbase = done_cnt;
    pulse_start();
    check("t1_busy_after_start", 32'(busy), 32'd1);
    check("t1_first_send", 32'(tx_send), 32'd1);
    check("t1_first_byte", 32'(tx_byte), 32'(SYNC));
    wait_done("t1", 400);
    check("t1_busy_with_done", 32'(busy), 32'd0);
    check("t1_checksum", 32'(checksum), 32'h24);
    @(negedge clk);
    check("t1_done_one_cycle", 32'(done), 32'd0);
    compare_frame("t1", base);
    check("t1_done_count", 32'(done_cnt - dbase), 32'd1);

    // T2: start pulsed while busy is ignored
    cycles(3);
    base  = sent.size();
    dbase = done_cnt;
    pulse_start();
    cycles(3);
    pulse_start();
    wait_done("t2", 400);
    cycles(30);
    compare_frame("t2", base);
    check("t2_done_count", 32'(done_cnt - dbase), 32'd1);
    check("t2_idle_busy", 32'(busy), 32'd0);

    // T3: abort during the third byte (0x02)
    base  = sent.size();
    dbase = done_cnt;
    abase = abort_cnt;
    pulse_start();
    wait_sent("t3", base + 3, 100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_aborted("t3", 100);
    check("t3_busy_at_abort", 32'(busy), 32'd0);
    check("t3_done_at_abort", 32'(done), 32'd0);
    cycles(30);
    check("t3_bytes_sent", 32'(sent.size() - base), 32'd3);
    if (sent.size() >= base + 3) check("t3_last_byte", 32'(sent[base + 2]), 32'h02);
    check("t3_done_count", 32'(done_cnt - dbase), 32'd0);
    check("t3_abort_count", 32'(abort_cnt - abase), 32'd1);

    // T4: reset mid-word, then a full fresh frame
    base = sent.size();
    pulse_start();
    wait_sent("t4", base + 4, 100);
    cycles(2);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("t4_reset");
    @(negedge clk);
    reset_n = 1'b1;
    cycles(3);
    base = sent.size();
    pulse_start();
    wait_done("t4", 400);
    compare_frame("t4", base);

    // T5: stray tx_done in IDLE, then start with abort
    cycles(5);
    base  = sent.size();
    dbase = done_cnt;
    abase = abort_cnt;
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    check("t5_busy_after_stray", 32'(busy), 32'd0);
    check("t5_send_after_stray", 32'(tx_send), 32'd0);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("t5_busy_start_abort", 32'(busy), 32'd0);
    check("t5_send_start_abort", 32'(tx_send), 32'd0);
    cycles(20);
    check("t5_no_bytes", 32'(sent.size() - base), 32'd0);
    check("t5_no_done", 32'(done_cnt - dbase), 32'd0);
    check("t5_no_aborted", 32'(abort_cnt - abase), 32'd0);

    // T6: random memory contents and start gaps
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] = $urandom;
      build_exp();
      cycles(int'($urandom_range(1, 8)));
      base = sent.size();
      pulse_start();
      wait_done($sformatf("t6_%0d", f), 400);
      check($sformatf("t6_%0d_checksum", f), 32'(checksum), 32'(exp_sum));
      compare_frame($sformatf("t6_%0d", f), base);
    end

    cycles(5);
    check("tx_byte_stable", 32'(stab_viol), 32'd0);
    check("no_double_send", 32'(twice_viol), 32'd0);
    check("addr_in_range", 32'(addr_viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
